// File: rtl/rr_arbiter.sv
// rr_arbiter: 4-way round-robin arbiter with bounded hold time, grant encoded for a 2-to-4 decoder.
module rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       x0,
  output logic       x1,
  output logic       e
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d, last_q, last_d, win;
  logic [7:0]  cnt_q, cnt_d;
  logic        found, hold;
  // Scan offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    win = last_q;
    for (int i = 4; i >= 1; i--)
      if (req[last_q + 2'(i)]) win = last_q + 2'(i);
  end
  assign found = |req;
  assign hold  = (state_q == GRANT) && req[idx_q] && (cnt_q < 8'(MAX_HOLD));
  always_comb begin
    state_d = (hold || found) ? GRANT : IDLE;
    idx_d   = (hold || !found) ? idx_q : win;
    last_d  = (hold || !found) ? last_q : win;
    cnt_d   = hold ? cnt_q + 8'd1 : found ? 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  assign x0 = idx_q[1];
  assign x1 = idx_q[0];
  assign e  = (state_q == IDLE);
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench, reference model predicts each cycle's grant from request history.
module tb_rr_arbiter;
  localparam int MH = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic x0, x1, e;
  typedef struct { logic e; logic [1:0] idx; int cnt; } exp_t;
  exp_t sb[$];
  int n_assert = 0, n_fail = 0;
  int m_holder = -1, m_last = 3, m_idx = 0, m_cnt = 0;
  rr_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .req(req), .x0(x0), .x1(x1), .e(e));
  always #5 clk = ~clk;
  // Apply one cycle of inputs and predict the outputs after the coming edge.
  task automatic step(input logic r, input logic [3:0] q);
    exp_t x;
    int w;
    rst = r;
    req = q;
    if (r) begin
      m_holder = -1; m_last = 3; m_idx = 0; m_cnt = 0;
    end else if (m_holder >= 0 && q[m_holder] && m_cnt < MH) begin
      m_cnt++;
    end else begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && q[(m_last + k) % 4]) w = (m_last + k) % 4;
      if (w >= 0) begin
        m_holder = w; m_last = w; m_idx = w; m_cnt = 1;
      end else begin
        m_holder = -1; m_cnt = 0;
      end
    end
    x.e = (m_holder < 0);
    x.idx = 2'(m_idx);
    x.cnt = m_cnt;
    sb.push_back(x);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_assert++;
      if ({e, x0, x1} !== {x.e, x.idx}) begin
        n_fail++;
        $display("FAIL grant t=%0t: got e=%b idx=%b%b, expected e=%b idx=%b", $time, e, x0, x1, x.e, x.idx);
      end
      if (!x.e) begin
        n_assert++;
        if (int'(dut.cnt_q) != x.cnt) begin
          n_fail++;
          $display("FAIL cnt t=%0t: got %0d, expected %0d", $time, dut.cnt_q, x.cnt);
        end
      end
    end
  end
  initial begin
    logic [3:0] r;
    @(negedge clk);
    step(1, 4'b0000); step(1, 4'b0000);
    repeat (5) step(0, 4'b0000);
    repeat (40) step(0, 4'b1111);
    step(1, 4'b0000);
    repeat (3) step(0, 4'b0100);
    repeat (3) step(0, 4'b0000);
    repeat (20) step(0, 4'b0010);
    step(1, 4'b0000);
    repeat (3) step(0, 4'b1000);
    step(0, 4'b1001);
    repeat (3) step(0, 4'b0001);
    step(1, 4'b0000);
    repeat (2) step(0, 4'b0100);
    step(0, 4'b0110);
    step(1, 4'b0110);
    repeat (4) step(0, 4'b0110);
    step(0, 4'b0000);
    step(0, 4'b1011);
    repeat (12) step(0, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      r = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) step(($urandom_range(0, 49) == 0), r);
    end
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)));
    step(0, 4'b0000);
    @(negedge clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 8, the maximum number of consecutive cycles one requester may hold a grant; legal range 1..255.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL provide port req, input, 4, request lines; req[i]=1 means requester i wants the shared resource.
REQ-005 SHALL provide port x0, output, 1, registered MSB of the granted index.
REQ-006 SHALL provide port x1, output, 1, registered LSB of the granted index.
REQ-007 SHALL provide port e, output, 1, registered active-high disable; 1 means no grant, 0 means {x0,x1} is the valid grant index.
REQ-008 SHALL drive x0/x1/e so that they connect directly to the downstream 2-to-4 one-hot decoder: granted index 0..3 asserts decoder output y0..y3.

Function
REQ-009 SHALL implement two states: IDLE (e=1) and GRANT (e=0).
REQ-010 SHALL hold a 2-bit last-granted pointer `last` and a hold counter `cnt` of width 8.
REQ-011 SHALL perform round-robin search in the order last+1, last+2, last+3, last+0 (mod 4); the winner is the first index with req=1.
REQ-012 IDLE: if any req bit is 1, SHALL enter GRANT next cycle with {x0,x1}=winner, e=0, last=winner, cnt=1; otherwise SHALL stay in IDLE.
REQ-013 Grant latency SHALL be exactly 1 cycle from the first edge at which req is sampled non-zero in IDLE.
REQ-014 GRANT: while req[{x0,x1}]=1 and cnt<MAX_HOLD, SHALL keep x0/x1/e unchanged and increment cnt.
REQ-015 GRANT release condition: req[{x0,x1}]=0, or cnt==MAX_HOLD.
REQ-016 On release, if the round-robin search finds a winner, SHALL move directly to the new grant next cycle (no IDLE bubble), with cnt=1 and last=winner.
REQ-017 The winner in REQ-016 MAY equal the current index only when no other requester is active; in that case cnt restarts at 1.
REQ-018 On release with no requests pending, SHALL enter IDLE next cycle with e=1; x0/x1 SHALL retain the last granted index.
REQ-019 Requests that assert or deassert while another grant is held SHALL NOT affect the held grant until the release condition holds.
REQ-020 With all four requesters permanently active, the grant SHALL rotate 0,1,2,3,0,..., each held exactly MAX_HOLD cycles.
REQ-021 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-022 cnt SHALL never exceed MAX_HOLD and SHALL never wrap.

Reset
REQ-023 While rst=1 at a clock edge, SHALL set state=IDLE, e=1, x0=0, x1=0, cnt=0, last=3, so the first search after reset starts at index 0.
REQ-024 Reset asserted mid-grant SHALL abort the grant; e=1 on the cycle after the reset edge, regardless of req.
REQ-025 On the first edge after rst deasserts, SHALL evaluate req normally per REQ-012.

Verification
REQ-026 Reset, then req=4'b0000 for 5 cycles -> e=1, x0=0, x1=0 throughout.
REQ-027 Post-reset req=4'b1111 held, MAX_HOLD=8 -> grant index 0 for 8 cycles, then 1, 2, 3, 0; each held 8 cycles; e=0 with no gap.
REQ-028 req=4'b0100 for 3 cycles, then 4'b0000 -> e=0, {x0,x1}=2'b10 starting 1 cycle later; held for 3 cycles; then e=1 with {x0,x1} still 2'b10.
REQ-029 Only req[1]=1, held 20 cycles, MAX_HOLD=8 -> grant index 1 continuous; cnt re-arms at cycles 9 and 17; e never rises.
REQ-030 Grant to index 3 active, req=4'b1001; drop req[3] -> next cycle grant index 0 (wrap-around), cnt=1.
REQ-031 rst pulsed for 1 cycle during the grant to index 2 with req=4'b0110 held -> e=1 one cycle; then grant index 1 (search from 0).
